// File: rtl/regfile_writeback_pkg.sv
// Shared types for the register-file writeback arbiter and its load-result buffer.
package regfile_writeback_pkg;

  localparam int XLEN     = 32;
  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 32;

  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_ALU  = 2'd1,
    WB_LBUF = 2'd2,
    WB_LBYP = 2'd3
  } wb_src_e;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;

endpackage

// File: rtl/regfile_writeback_fifo.sv
// Synchronous FIFO of pending load writebacks; head is visible combinationally.
module regfile_wb_fifo
  import regfile_writeback_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  wb_req_t                      push_data,
  input  logic                         pop,
  output wb_req_t                      head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  wb_req_t       mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read while count is non-zero.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == CW'(0));

endmodule

// File: rtl/regfile_writeback.sv
// Writeback arbiter for the register-file write port (ALU > buffered load > new load).
// Optional busy scoreboard enabled by defining REGFILE_WB_SCOREBOARD_EN.
module regfile_writeback
  import regfile_writeback_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int REG_AW   = 5,
  parameter int LQ_DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      alu_valid,
  input  logic [REG_AW-1:0]         alu_rd,
  input  logic [XLEN-1:0]           alu_data,
  input  logic                      ld_valid,
  output logic                      ld_ready,
  input  logic [REG_AW-1:0]         ld_rd,
  input  logic [XLEN-1:0]           ld_data,
  input  logic                      issue_valid,
  input  logic [REG_AW-1:0]         issue_rd,
  output logic                      rf_we,
  output logic [REG_AW-1:0]         rf_waddr,
  output logic [XLEN-1:0]           rf_wdata,
  output logic [(1<<REG_AW)-1:0]    sb_busy
);

  logic                          full;
  logic                          empty;
  logic                          accept;
  logic                          push;
  logic                          pop;
  logic [$clog2(LQ_DEPTH+1)-1:0] lq_count;
  wb_req_t                       head;
  wb_req_t                       ld_req;
  wb_req_t                       win;
  wb_src_e                       src;

  assign ld_ready = ~full & rst_n;
  assign accept   = ld_valid & ld_ready;
  assign ld_req   = '{rd: ld_rd, data: ld_data};

  regfile_wb_fifo #(.DEPTH(LQ_DEPTH)) u_lq (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (ld_req),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (lq_count)
  );

  // Pick this cycle's writer and decide whether the incoming load is queued.
  always_comb begin
    src  = WB_NONE;
    push = 1'b0;
    pop  = 1'b0;
    win  = '0;
    if (alu_valid) begin
      src  = WB_ALU;
      push = accept;
      win  = '{rd: alu_rd, data: alu_data};
    end else if (!empty) begin
      src  = WB_LBUF;
      pop  = 1'b1;
      push = accept;
      win  = head;
    end else if (accept) begin
      src  = WB_LBYP;
      win  = ld_req;
    end else begin
      src  = WB_NONE;
    end
  end

  // Registered write port; x0 results are consumed without a write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= (src != WB_NONE) && (win.rd != '0);
      if (src != WB_NONE) begin
        rf_waddr <= win.rd;
        rf_wdata <= win.data;
      end
    end
  end

`ifdef REGFILE_WB_SCOREBOARD_EN
  logic [(1<<REG_AW)-1:0] set_mask;
  logic [(1<<REG_AW)-1:0] clr_mask;
  logic                   unused_sb;

  assign unused_sb = ^lq_count;

  // Clears come from load-path commits; a same-cycle issue re-sets the bit.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (issue_valid && (issue_rd != '0)) set_mask[issue_rd] = 1'b1;
    else set_mask = '0;
    if (((src == WB_LBUF) || (src == WB_LBYP)) && (win.rd != '0)) clr_mask[win.rd] = 1'b1;
    else clr_mask = '0;
  end

  // Busy bits update on the same edge the load write is registered.
  always_ff @(posedge clk) begin
    if (!rst_n) sb_busy <= '0;
    else        sb_busy <= (sb_busy & ~clr_mask) | set_mask;
  end
`else
  logic unused_sb;

  assign unused_sb = ^{issue_valid, issue_rd, lq_count};
  assign sb_busy   = '0;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Randomized + directed bench for regfile_writeback against a queue-based reference model.
module tb_regfile_writeback;

  localparam int LQ_DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] sb_busy;

  regfile_writeback #(.XLEN(32), .REG_AW(5), .LQ_DEPTH(LQ_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .sb_busy(sb_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        lq[$];
  logic        exp_we;
  logic [4:0]  exp_waddr;
  logic [31:0] exp_wdata;
  logic [31:0] exp_busy;
  logic        exp_rst;
  logic        primed;
  logic        last_acc;
  int          n_vec;
  int          n_miss;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One cycle: drive inputs at negedge, check registered outputs, advance the model.
  task automatic step(input logic r, input logic av, input logic [4:0] ard, input logic [31:0] ad,
                      input logic lv, input logic [4:0] lrd, input logic [31:0] ldd,
                      input logic iv, input logic [4:0] ird);
    logic exp_ready;
    logic acc;
    logic has_w;
    logic from_ld;
    ent_t w;
    rst_n = r; alu_valid = av; alu_rd = ard; alu_data = ad;
    ld_valid = lv; ld_rd = lrd; ld_data = ldd; issue_valid = iv; issue_rd = ird;
    #1;
    exp_ready = r && (lq.size() < LQ_DEPTH);
    check("ld_ready", {63'd0, ld_ready}, {63'd0, exp_ready});
    if (primed) begin
      check("rf_we", {63'd0, rf_we}, {63'd0, exp_we});
      if (exp_we || exp_rst) begin
        check("rf_waddr", {59'd0, rf_waddr}, {59'd0, exp_waddr});
        check("rf_wdata", {32'd0, rf_wdata}, {32'd0, exp_wdata});
      end
      check("sb_busy", {32'd0, sb_busy}, {32'd0, exp_busy});
    end
    acc      = lv && exp_ready;
    last_acc = acc;
    has_w    = 1'b0;
    from_ld  = 1'b0;
    w        = '{rd: 5'd0, data: 32'd0};
    if (!r) begin
      lq.delete();
      exp_we = 1'b0; exp_waddr = 5'd0; exp_wdata = 32'd0; exp_busy = 32'd0;
      exp_rst = 1'b1;
    end else begin
      exp_rst = 1'b0;
      if (av) begin
        has_w = 1'b1; w = '{rd: ard, data: ad};
        if (acc) lq.push_back('{rd: lrd, data: ldd});
      end else if (lq.size() > 0) begin
        has_w = 1'b1; from_ld = 1'b1; w = lq.pop_front();
        if (acc) lq.push_back('{rd: lrd, data: ldd});
      end else if (acc) begin
        has_w = 1'b1; from_ld = 1'b1; w = '{rd: lrd, data: ldd};
      end
      exp_we = has_w && (w.rd != 5'd0);
      if (exp_we) begin
        exp_waddr = w.rd;
        exp_wdata = w.data;
      end
`ifdef REGFILE_WB_SCOREBOARD_EN
      if (from_ld && w.rd != 5'd0) exp_busy[w.rd] = 1'b0;
      if (iv && ird != 5'd0) exp_busy[ird] = 1'b1;
`endif
    end
    primed = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
  endtask

  initial begin
    n_vec = 0; n_miss = 0; primed = 1'b0; exp_rst = 1'b1; last_acc = 1'b0;
    exp_we = 1'b0; exp_waddr = 5'd0; exp_wdata = 32'd0; exp_busy = 32'd0;
    @(negedge clk);
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    step(1'b0, 1'b1, 5'd9, 32'h1234, 1'b1, 5'd1, 32'h5, 1'b1, 5'd3);

    // Single ALU write.
    step(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    idle(1);

    // ALU and load in the same cycle.
    step(1'b1, 1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, 1'b0, 5'd0);
    idle(2);

    // Three loads under continuous ALU; the third waits for space.
    step(1'b1, 1'b1, 5'd20, 32'hA0, 1'b1, 5'd7, 32'h77, 1'b0, 5'd0);
    step(1'b1, 1'b1, 5'd21, 32'hA1, 1'b1, 5'd8, 32'h88, 1'b0, 5'd0);
    step(1'b1, 1'b1, 5'd22, 32'hA2, 1'b1, 5'd9, 32'h99, 1'b0, 5'd0);
    last_acc = 1'b0;
    for (int k = 0; k < 8 && !last_acc; k++) step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99, 1'b0, 5'd0);
    check("ld9_accepted", {63'd0, last_acc}, 64'd1);
    idle(3);

    // Load to x0.
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0);
    idle(1);

    // Scoreboard set, clear, and same-cycle set-over-clear.
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd10);
    idle(1);
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 32'hCAFE, 1'b0, 5'd0);
    idle(1);
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 32'hBEEF, 1'b1, 5'd10);
    idle(2);

    // Two buffered loads discarded by reset.
    step(1'b1, 1'b1, 5'd1, 32'h1, 1'b1, 5'd11, 32'hB1, 1'b1, 5'd11);
    step(1'b1, 1'b1, 5'd2, 32'h2, 1'b1, 5'd12, 32'hB2, 1'b0, 5'd0);
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    idle(3);
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd12);
    idle(2);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 63) != 0), ($urandom_range(0, 2) == 0),
           5'($urandom_range(0, 31)), $urandom,
           ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 31)), $urandom,
           ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 31)));
    end
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/regfile_writeback.md
# regfile_writeback

Writeback arbiter that drives the single write port of the 32×32 register file. Merges the fixed-latency ALU result stream with a variable-latency load/long-op result stream (valid/ready), buffers load results that lose arbitration, and keeps a per-register busy scoreboard for the issue stage. Sits between the execute/memory stages and the register file write port. It is the writer side of that port.

## Interface
- XLEN, 32, data width
- REG_AW, 5, register address width
- LQ_DEPTH, 2, load-result buffer entries (power of 2, ≥2)

- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- alu_valid  in  1  ALU result present this cycle (no backpressure)
- alu_rd  in  REG_AW  ALU destination
- alu_data  in  XLEN  ALU result
- ld_valid  in  1  load/long-op result offered
- ld_ready  out  1  buffer can accept a load result
- ld_rd  in  REG_AW  load destination
- ld_data  in  XLEN  load result
- issue_valid  in  1  long-latency op issued this cycle
- issue_rd  in  REG_AW  its destination
- rf_we  out  1  register file write enable
- rf_waddr  out  REG_AW  register file write address
- rf_wdata  out  XLEN  register file write data
- sb_busy  out  2^REG_AW  bit i = register i has a pending long-latency write

## Operation
- Load handshake: transfer when ld_valid && ld_ready. ld_ready = !full && rst_n.
- Arbitration each cycle, priority ALU > buffered load > incoming load.
  - alu_valid: ALU result is the write. Any accepted load is pushed into the buffer.
  - else buffer non-empty: pop the head and write it. Any accepted load is pushed, so push and pop can occur in the same cycle.
  - else accepted load bypasses the buffer and is written directly.
- Buffer is FIFO. Loads are written in acceptance order. Count is 0..LQ_DEPTH. Pointers wrap modulo LQ_DEPTH.
- Destination x0: the result is consumed (handshake, pop) but rf_we=0. x0 never marks the scoreboard busy.
- Scoreboard:
  - Set bit issue_rd on issue_valid && issue_rd!=0.
  - Clear bit on a committed load-path write to that rd.
  - Set and clear of the same rd in the same cycle: set wins.
  - ALU writes never clear bits.
- Issuing to an already-busy rd is an upstream error. The bit stays set. No WAW tracking beyond one bit.

## Timing
- rf_we/rf_waddr/rf_wdata are registered: the write is presented exactly 1 cycle after the winning input cycle. The register file then commits it on the following edge.
- Latency:
  - ALU: 1 cycle.
  - Load, buffer empty, no ALU: 1 cycle.
  - Buffered load: 1 cycle after the first cycle it wins arbitration.
- sb_busy is registered. A set is visible the cycle after issue_valid. A clear is visible in the same cycle rf_we presents the write.
- ld_ready depends only on registered count, not on alu_valid. A full buffer with no ALU pops, and ld_ready rises the next cycle.
- Reset values: rf_we=0, rf_waddr=0, rf_wdata=0, sb_busy=0, count=0, pointers=0, ld_ready=0 while rst_n=0.
- Reset mid-operation: buffered entries are discarded with no write, and a write presented that cycle is dropped (rf_we=0 next cycle).
- Sustained alu_valid starves the buffer. Upstream guarantees ALU bubbles. No fairness counter.

## Configuration
- REGFILE_WB_SCOREBOARD_EN defined: scoreboard as above.
- Not defined: no scoreboard flops. sb_busy is tied to 0, issue_valid/issue_rd are ignored, and all other behaviour is identical.

## Structure
- Shared package holds:
  - constants XLEN, REG_AW, NUM_REGS=32;
  - typedef wb_src_e {WB_NONE, WB_ALU, WB_LBUF, WB_LBYP};
  - struct wb_req_t {rd, data}.
- One sub-module: regfile_wb_fifo, a synchronous FIFO of wb_req_t with push/pop/full/empty/count. The arbiter, scoreboard and output register live in the top.

## Test plan
- Reset then alu_valid, rd=5, data=0xDEADBEEF: rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF one cycle later. All outputs are 0 during reset.
- Same-cycle ALU(rd=3, 0x11) and load(rd=4, 0x22):
  - cycle+1 writes x3=0x11;
  - cycle+2 writes x4=0x22;
  - ld_ready stays 1.
- Three loads back-to-back (rd 7, 8, 9, LQ_DEPTH=2) under continuous alu_valid: ld_ready drops after the 2nd. After ALU stops, writes to x7, x8, x9 appear in order on consecutive cycles.
- Load to rd=0 with data 0xFFFF: handshake completes, rf_we stays 0, sb_busy unchanged.
- Scoreboard, macro defined:
  - issue rd=10 → sb_busy[10]=1 next cycle;
  - load rd=10 accepted → bit clears when rf_we presents x10;
  - simultaneous issue rd=10 and commit of x10 leaves the bit set.
- Two loads buffered, then rst_n=0 for 1 cycle: no rf_we afterwards, count=0, sb_busy=0. Macro undefined: sb_busy stays 0 through an issue rd=12.
